branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Program-sequencing block that consumes the condition flags (Carry, SCarry, gtFlag) produced by the flag register and turns them into control flow. It owns the program counter, resolves conditional branches through a loadable branch-target table, issues the flag-clear pulse back to the flag register when a branch consumes the flags, and runs the Start/Done handshake with the test harness. It sits between the instruction decoder (branch/halt fields) and the instruction ROM address input.

## Interface
- PC_W, 10, program counter / branch target width
- LUT_AW, 4, branch-target table address width (2**LUT_AW entries)

- Clk  input  1  clock, all state updates on rising edge
- Res  input  1  reset, asynchronous, active-low
- Start  input  1  launch request from harness, level
- Halt  input  1  decoded halt instruction at current PC
- BrEn  input  1  decoded instruction is a conditional branch
- BrCond  input  3  branch condition code
- BrIdx  input  LUT_AW  branch-target table index
- Carry  input  1  carry flag from flag register
- SCarry  input  1  shift-carry flag from flag register
- gtFlag  input  1  greater-than flag from flag register
- LutWe  input  1  table write enable
- LutAddr  input  LUT_AW  table write address
- LutData  input  PC_W  table write data (absolute target PC)
- PC  output  PC_W  current instruction address, registered
- Taken  output  1  registered, high one cycle after a taken branch
- FlagClr  output  1  combinational, drives the flag register Clear input
- Busy  output  1  high in RUN
- Done  output  1  high in DONE

## Operation
- States: IDLE, RUN, DONE (2-bit encoded, registered).
- IDLE: PC held at 0. Start=1 -> RUN; PC stays 0 (first instruction fetched at 0).
- RUN, priority per cycle: Halt -> DONE, PC unchanged; else BrEn and condition true -> PC <= LUT[BrIdx], Taken <= 1; else PC <= PC+1 modulo 2**PC_W (wraps max to 0).
- Start ignored while in RUN and DONE.
- DONE: Done=1, PC frozen. Start=0 -> IDLE (PC <= 0). Start held high keeps DONE.
- Condition codes: 000 always; 001 Carry; 010 !Carry; 011 SCarry; 100 gtFlag; 101 !gtFlag; 110 Carry|gtFlag; 111 never (reserved, not taken).
- FlagClr = (state==RUN) & BrEn & !Halt & condition true; combinational so the flag register clears on the same edge the PC is redirected. Never asserted for not-taken branches or outside RUN.
- Halt and BrEn together: Halt wins, no branch, FlagClr=0, Taken stays 0.
- Table: 2**LUT_AW x PC_W registers, all zero on reset. Write on LutWe at rising edge in any state. Same-cycle write and branch read of the same index: branch uses the old value.

## Timing
- Reset (Res=0, async): state IDLE, PC=0, Taken=0, Busy=0, Done=0, all table entries 0. FlagClr=0 during reset (state is IDLE).
- Reset asserted mid-RUN: immediate return to reset values, no pending branch completes.
- Start sampled at edge k in IDLE -> Busy=1 after edge k.
- Branch decision at edge k -> PC=target and Taken=1 after edge k; Taken drops after edge k+1 unless another taken branch.
- Flags are sampled in the same cycle the branch is decoded; no extra latency, no bypass.
- Halt at edge k -> Done=1, Busy=0 after edge k; Start=0 at edge m>k -> Done=0, PC=0 after edge m.

## Test plan
- Reset then Start=1 one cycle, no branches, 5 cycles -> PC 0,1,2,3,4,5; Busy=1; Taken=0; FlagClr=0 throughout.
- Load LUT[3]=0x120, in RUN BrEn=1 BrCond=001 BrIdx=3 Carry=1 -> FlagClr=1 that cycle, next PC=0x120, Taken=1 one cycle; repeat with Carry=0 -> PC+1, FlagClr=0.
- Sweep all 8 BrCond codes against all 8 flag combinations -> taken exactly per condition table; 111 never taken.
- PC at 0x3FF, no branch -> PC=0x000 next cycle; Halt and BrEn=1/BrCond=000 same cycle -> DONE, PC unchanged, FlagClr=0.
- DONE with Start held high 4 cycles -> stays DONE; Start=0 -> IDLE, PC=0, Done=0; Start=1 -> RUN again.
- Mid-RUN Res=0 between edges -> PC=0, Busy=0, Taken=0 immediately; same-cycle LutWe to index 5 (0x055) and taken branch via index 5 (old 0x011) -> PC=0x011, following branch via 5 -> 0x055.

Source files
------------

// File: rtl/branch_ctrl.sv
// Program sequencer: owns the PC, resolves conditional branches through a
// loadable target table and runs the Start/Done handshake with the harness.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for Start, PC held at 0
// RUN   | fetching: halt, taken branch or sequential PC advance
// DONE  | halted, PC frozen until Start is released
module branch_ctrl #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 4
) (
  input  logic              Clk,
  input  logic              Res,
  input  logic              Start,
  input  logic              Halt,
  input  logic              BrEn,
  input  logic [2:0]        BrCond,
  input  logic [LUT_AW-1:0] BrIdx,
  input  logic              Carry,
  input  logic              SCarry,
  input  logic              gtFlag,
  input  logic              LutWe,
  input  logic [LUT_AW-1:0] LutAddr,
  input  logic [PC_W-1:0]   LutData,
  output logic [PC_W-1:0]   PC,
  output logic              Taken,
  output logic              FlagClr,
  output logic              Busy,
  output logic              Done
);

  localparam int LUT_N = 2 ** LUT_AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic            taken_nxt;
  logic            cond_true;
  logic            br_take;
  logic [PC_W-1:0] lut [LUT_N];

  always_comb begin
    cond_true = 1'b0;
    case (BrCond)
      3'b000:  cond_true = 1'b1;
      3'b001:  cond_true = Carry;
      3'b010:  cond_true = !Carry;
      3'b011:  cond_true = SCarry;
      3'b100:  cond_true = gtFlag;
      3'b101:  cond_true = !gtFlag;
      3'b110:  cond_true = Carry | gtFlag;
      default: cond_true = 1'b0;
    endcase
  end

  // Halt has priority, so a halting instruction never consumes the flags.
  assign br_take = (state == RUN) && BrEn && !Halt && cond_true;
  assign FlagClr = br_take;
  assign Busy    = (state == RUN);
  assign Done    = (state == DONE);

  always_ff @(posedge Clk or negedge Res) begin
    if (!Res) begin
      state <= IDLE;
      PC    <= '0;
      Taken <= 1'b0;
    end else begin
      state <= state_nxt;
      PC    <= pc_nxt;
      Taken <= taken_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = PC;
    taken_nxt = 1'b0;
    case (state)
      IDLE: begin
        pc_nxt = '0;
        if (Start) state_nxt = RUN;
      end
      RUN: begin
        if (Halt) begin
          state_nxt = DONE;
        end else if (br_take) begin
          pc_nxt    = lut[BrIdx];
          taken_nxt = 1'b1;
        end else begin
          pc_nxt = PC + PC_W'(1);
        end
      end
      DONE: begin
        if (!Start) begin
          state_nxt = IDLE;
          pc_nxt    = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        pc_nxt    = '0;
      end
    endcase
  end

  // Branch reads the combinational table output, so a same-edge write lands
  // after the read and the branch sees the old entry.
  always_ff @(posedge Clk or negedge Res) begin
    if (!Res) begin
      for (int i = 0; i < LUT_N; i++) lut[i] <= '0;
    end else if (LutWe) begin
      lut[LutAddr] <= LutData;
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed steps plus a randomized run,
// all compared against a behavioural model of the sequencer.
module tb_branch_ctrl;

  logic       Clk = 1'b0;
  logic       Res = 1'b1;
  logic       Start = 1'b0, Halt = 1'b0, BrEn = 1'b0;
  logic [2:0] BrCond = '0;
  logic [3:0] BrIdx = '0;
  logic       Carry = 1'b0, SCarry = 1'b0, gtFlag = 1'b0;
  logic       LutWe = 1'b0;
  logic [3:0] LutAddr = '0;
  logic [9:0] LutData = '0;
  logic [9:0] PC;
  logic       Taken, FlagClr, Busy, Done;

  int checks = 0;
  int failures = 0;

  // model: 0 = waiting, 1 = running, 2 = finished
  int m_mode;
  int m_pc;
  int m_taken;
  int m_lut [16];

  always #5 Clk = ~Clk;

  branch_ctrl #(.PC_W(10), .LUT_AW(4)) dut (
    .Clk(Clk), .Res(Res), .Start(Start), .Halt(Halt), .BrEn(BrEn),
    .BrCond(BrCond), .BrIdx(BrIdx), .Carry(Carry), .SCarry(SCarry),
    .gtFlag(gtFlag), .LutWe(LutWe), .LutAddr(LutAddr), .LutData(LutData),
    .PC(PC), .Taken(Taken), .FlagClr(FlagClr), .Busy(Busy), .Done(Done)
  );

  function automatic int cond_ok(int c, int cy, int sc, int gt);
    case (c)
      0:       return 1;
      1:       return cy;
      2:       return 1 - cy;
      3:       return sc;
      4:       return gt;
      5:       return 1 - gt;
      6:       return (cy + gt > 0) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_take();
    return (m_mode == 1 && BrEn && !Halt &&
            cond_ok(int'(BrCond), int'(Carry), int'(SCarry), int'(gtFlag)) == 1) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc = 0;
    m_taken = 0;
    for (int i = 0; i < 16; i++) m_lut[i] = 0;
  endtask

  task automatic model_step();
    int take;
    take = exp_take();
    m_taken = 0;
    if (m_mode == 0) begin
      m_pc = 0;
      if (Start) m_mode = 1;
    end else if (m_mode == 1) begin
      if (Halt) m_mode = 2;
      else if (take == 1) begin
        m_pc = m_lut[BrIdx];
        m_taken = 1;
      end else m_pc = (m_pc + 1) % 1024;
    end else if (!Start) begin
      m_mode = 0;
      m_pc = 0;
    end
    if (LutWe) m_lut[LutAddr] = int'(LutData);
  endtask

  task automatic check_outputs(input string where);
    chk({where, "_pc"},    32'(PC),    32'(m_pc));
    chk({where, "_taken"}, 32'(Taken), 32'(m_taken));
    chk({where, "_busy"},  32'(Busy),  32'(m_mode == 1));
    chk({where, "_done"},  32'(Done),  32'(m_mode == 2));
  endtask

  // Entered and left at posedge+1; inputs are already set by the caller.
  task automatic cycle();
    #1;
    chk("flagclr", 32'(FlagClr), 32'(exp_take()));
    @(posedge Clk);
    model_step();
    #1;
    check_outputs("cyc");
  endtask

  task automatic apply_reset();
    Res = 1'b0;
    #1;
    model_reset();
    check_outputs("rst");
    chk("rst_flagclr", 32'(FlagClr), 32'd0);
    @(posedge Clk);
    #1;
    check_outputs("rst_hold");
    Res = 1'b1;
  endtask

  task automatic idle_inputs();
    Start = 0; Halt = 0; BrEn = 0; LutWe = 0;
    BrCond = '0; BrIdx = '0; Carry = 0; SCarry = 0; gtFlag = 0;
  endtask

  initial begin
    model_reset();
    #3;
    apply_reset();

    // launch and run sequentially
    Start = 1; cycle();
    Start = 0;
    for (int i = 0; i < 5; i++) cycle();
    chk("seq_pc5", 32'(PC), 32'h5);

    // conditional branch on Carry, taken then not taken
    LutWe = 1; LutAddr = 4'd3; LutData = 10'h120; cycle();
    LutWe = 0;
    BrEn = 1; BrCond = 3'b001; BrIdx = 4'd3; Carry = 1;
    #1; chk("carry_flagclr", 32'(FlagClr), 32'd1);
    cycle();
    chk("carry_target", 32'(PC), 32'h120);
    chk("carry_taken", 32'(Taken), 32'd1);
    BrEn = 0; cycle();
    chk("taken_drop", 32'(Taken), 32'd0);
    BrEn = 1; Carry = 0; cycle();
    chk("nocarry_pc", 32'(PC), 32'h122);
    idle_inputs();

    // random table contents, then full condition/flag sweep
    for (int i = 0; i < 16; i++) begin
      LutWe = 1; LutAddr = 4'(i); LutData = 10'($urandom_range(0, 1023));
      cycle();
    end
    LutWe = 0;
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        BrEn = 1; BrCond = 3'(c); BrIdx = 4'($urandom_range(0, 15));
        {Carry, SCarry, gtFlag} = 3'(f);
        cycle();
      end
    end
    idle_inputs();

    // randomized mixed traffic
    for (int i = 0; i < 300; i++) begin
      Start  = 1'($urandom_range(0, 1));
      Halt   = ($urandom_range(0, 15) == 0);
      BrEn   = 1'($urandom_range(0, 1));
      BrCond = 3'($urandom_range(0, 7));
      BrIdx  = 4'($urandom_range(0, 15));
      {Carry, SCarry, gtFlag} = 3'($urandom_range(0, 7));
      LutWe  = ($urandom_range(0, 3) == 0);
      LutAddr = 4'($urandom_range(0, 15));
      LutData = 10'($urandom_range(0, 1023));
      cycle();
    end
    idle_inputs();

    // PC wrap, then Halt beating a same-cycle branch
    apply_reset();
    Start = 1; cycle();
    Start = 0;
    LutWe = 1; LutAddr = 4'd7; LutData = 10'h3FE; cycle();
    LutWe = 0;
    BrEn = 1; BrCond = 3'b000; BrIdx = 4'd7; cycle();
    BrEn = 0; cycle();
    chk("wrap_max", 32'(PC), 32'h3FF);
    cycle();
    chk("wrap_zero", 32'(PC), 32'h000);
    cycle();
    Halt = 1; BrEn = 1; BrCond = 3'b000; BrIdx = 4'd7;
    #1; chk("halt_flagclr", 32'(FlagClr), 32'd0);
    cycle();
    chk("halt_pc", 32'(PC), 32'h001);
    chk("halt_done", 32'(Done), 32'd1);
    chk("halt_taken", 32'(Taken), 32'd0);

    // DONE holds while Start is high, releases to IDLE, relaunches
    Halt = 0; BrEn = 0; Start = 1;
    for (int i = 0; i < 4; i++) cycle();
    chk("done_hold", 32'(Done), 32'd1);
    Start = 0; cycle();
    chk("done_release_pc", 32'(PC), 32'h0);
    Start = 1; cycle();
    chk("relaunch_busy", 32'(Busy), 32'd1);
    Start = 0;

    // reset in the middle of a taken branch
    BrEn = 1; BrCond = 3'b000; BrIdx = 4'd7; cycle();
    BrEn = 0;
    apply_reset();

    // same-edge table write and branch read use the old entry
    Start = 1; cycle();
    Start = 0;
    LutWe = 1; LutAddr = 4'd3; LutData = 10'h0AA; cycle();
    BrEn = 1; BrCond = 3'b000; BrIdx = 4'd3; LutWe = 0; cycle();
    chk("lut3_after_write", 32'(PC), 32'h0AA);
    BrEn = 0;
    LutWe = 1; LutAddr = 4'd5; LutData = 10'h011; cycle();
    LutData = 10'h055; BrEn = 1; BrCond = 3'b000; BrIdx = 4'd5; cycle();
    chk("old_entry", 32'(PC), 32'h011);
    LutWe = 0; cycle();
    chk("new_entry", 32'(PC), 32'h055);
    idle_inputs();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
